coreuart_fifo_gen2: RTL and testbench
=====================================

// Module: coreuart_fifo_gen2
// PURPOSE
//  Next-generation CoreUART: async serial TX/RX with 16x-oversampled baud generator and parametrised
//  FWFT FIFOs on both paths. Adds 2-stop-bit mode, FIFO fill levels, sticky error flags and false-start
//  rejection. Sits behind the APB wrapper, driven by the same CSN/WEN/OEN strobe interface.
// PARAMETERS
//  TX_DEPTH   16  TX FIFO entries, power of 2, 2..256
//  RX_DEPTH   16  RX FIFO entries, power of 2, 2..256
//  LVL_W      5   fill-level width, = log2(max(TX_DEPTH,RX_DEPTH))+1
// PORTS
//  CLK          in   1      system clock, all logic rising-edge
//  RESET_N      in   1      synchronous, active-low reset
//  CSN          in   1      chip select, active low
//  WEN          in   1      write strobe, active low; CSN=0&WEN=0 pushes DATA_IN to TX FIFO
//  OEN          in   1      read strobe, active low; CSN=0&OEN=0 reads DATA_OUT and pops RX FIFO
//  DATA_IN      in   8      TX write data
//  RX           in   1      serial input, asynchronous
//  BAUD_VAL     in   13     oversample tick every BAUD_VAL+1 clocks
//  BIT8         in   1      1: 8 data bits; 0: 7 data bits (bit 7 of RX data = 0)
//  PARITY_EN    in   1      parity bit enabled
//  ODD_N_EVEN   in   1      1: odd parity; 0: even parity
//  STOP2        in   1      1: two stop bits on TX, RX checks both
//  DATA_OUT     out  8      head of RX FIFO (FWFT); 0x00 when empty
//  TX           out  1      serial output, idle high
//  TXRDY        out  1      TX FIFO not full
//  RXRDY        out  1      RX FIFO not empty
//  PARITY_ERR   out  1      sticky: parity mismatch on a received frame
//  FRAMING_ERR  out  1      sticky: stop bit sampled 0
//  OVERFLOW     out  1      sticky: frame completed with RX FIFO full (frame dropped)
//  TX_LEVEL     out  LVL_W  TX FIFO occupancy
//  RX_LEVEL     out  LVL_W  RX FIFO occupancy
// BEHAVIOUR
//  Reset (RESET_N=0 at CLK edge): FIFOs empty, FSMs IDLE; TX=1, TXRDY=1, RXRDY=0, DATA_OUT=0,
//   all error flags 0, levels 0. Reset mid-frame aborts the frame; TX returns high the next cycle.
//  Baud gen: 13-bit down counter loaded with BAUD_VAL; tick is a 1-clk pulse at 0; bit time = 16 ticks.
//   BAUD_VAL is sampled on reload only; a change takes effect after the current count.
//  Write access: each cycle with CSN=0&WEN=0 is one push. Push when full is dropped; TX FIFO unchanged.
//  Read access: pop on the first cycle of a CSN=0&OEN=0 run (edge-detected); pop when empty is ignored.
//   The same cycle clears PARITY_ERR, FRAMING_ERR and OVERFLOW; a set in the same cycle wins.
//  TX FSM: IDLE->START->DATA->[PARITY]->STOP1->[STOP2]->IDLE, 16 ticks per state, LSB first.
//   IDLE leaves on the first tick with the TX FIFO not empty. FIFO pops on entry to START.
//   Back-to-back frames have no idle gap. Parity = XOR of the 7 or 8 data bits, inverted if ODD_N_EVEN.
//  RX: two-flop synchroniser on RX. IDLE->START on sync'd 1->0. START samples at tick 8: 1 returns to
//   IDLE (false start, no flags); 0 goes to DATA. Each bit is sampled at tick 8 of its window.
//   STOP: 0 sets FRAMING_ERR. The frame is still stored if the FIFO has room.
//   With STOP2, either stop bit 0 sets the flag.
//   Frame done: push data; if full, drop and set OVERFLOW. Parity mismatch sets PARITY_ERR; data stored.
//   After a framing error RX waits for line high before re-arming.
//  FIFO: dual-pointer RAM, pointers wrap at DEPTH; level = wr-rd in LVL_W bits.
//   Simultaneous push and pop: level unchanged, valid even when full or empty.
//   Push to an empty RX FIFO: DATA_OUT and RXRDY update the next cycle.
//  Config inputs (BIT8, PARITY_EN, ODD_N_EVEN, STOP2) are sampled at frame start; changes mid-frame
//   apply to the next frame.
// TESTING
//  Reset: RESET_N=0 two cycles mid-TX -> TX=1, TXRDY=1, RXRDY=0, flags 0, levels 0 next cycle
//  TX timing: BAUD_VAL=0, 8N1, write 0x55 -> TX: start 0, bits 1010 1010 LSB first, 16 clk each,
//   stop 1; frame 160 clks
//  Loopback TX->RX, 8 data bits, odd parity, STOP2, write 0xA5,0x3C -> RX_LEVEL=2, DATA_OUT=0xA5
//   then 0x3C after a read, no flags
//  TX full: TX_DEPTH=16, write 17 bytes with TX stalled (BAUD_VAL=8191) -> TXRDY=0, TX_LEVEL=16;
//   17th byte never transmitted
//  RX overflow: RX_DEPTH=4, send 5 frames, no reads -> OVERFLOW=1, RX_LEVEL=4, first 4 bytes intact;
//   one read -> OVERFLOW=0
//  Errors: 4-clk low glitch at BAUD_VAL=0 -> no frame; frame with stop=0 -> FRAMING_ERR=1;
//   bad parity -> PARITY_ERR=1; both cleared by a read

Source files
------------

// File: rtl/coreuart_fifo_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coreuart_fifo_gen2 : 16x-oversampled UART TX/RX with FWFT FIFOs,          |
// |                      sticky error flags and false-start rejection.        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+

module coreuart_fifo_gen2_fifo #(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    w_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Extra pointer bit distinguishes full from empty; index wraps at DEPTH.
    assign w_count   = wr_q - rd_q;
    assign empty_o   = (w_count == '0);
    assign full_o    = (w_count == PW'(DEPTH));
    assign w_pop_ok  = pop_i && !empty_o;
    assign w_push_ok = push_i && (!full_o || w_pop_ok);
    assign rdata_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    assign level_o   = LVL_W'(w_count);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (w_push_ok) wr_q <= wr_q + PW'(1);
            if (w_pop_ok)  rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

module coreuart_fifo_gen2 #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int LVL_W    = 5
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             csn_i,
    input  logic             wen_i,
    input  logic             oen_i,
    input  logic [7:0]       data_in_i,
    input  logic             rx_i,
    input  logic [12:0]      baud_val_i,
    input  logic             bit8_i,
    input  logic             parity_en_i,
    input  logic             odd_n_even_i,
    input  logic             stop2_i,
    output logic [7:0]       data_out_o,
    output logic             tx_o,
    output logic             txrdy_o,
    output logic             rxrdy_o,
    output logic             parity_err_o,
    output logic             framing_err_o,
    output logic             overflow_o,
    output logic [LVL_W-1:0] tx_level_o,
    output logic [LVL_W-1:0] rx_level_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;
    localparam logic [2:0] S_WAITHI = 3'd6;

    logic [12:0] baud_cnt_q;
    logic        w_tick;
    logic        rd_prev_q;
    logic        w_rd_edge;
    logic [7:0]  w_tx_head;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic        w_rx_empty;
    logic        w_rx_full;

    assign w_tick    = (baud_cnt_q == 13'd0);
    assign w_rd_edge = !csn_i && !oen_i && !rd_prev_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            baud_cnt_q <= 13'd0;
            rd_prev_q  <= 1'b0;
        end else begin
            baud_cnt_q <= w_tick ? baud_val_i : baud_cnt_q - 13'd1;
            rd_prev_q  <= !csn_i && !oen_i;
        end
    end

    // ---------------- transmitter ----------------
    logic [2:0] tx_state_q, tx_state_d;
    logic [3:0] tx_tcnt_q;
    logic [2:0] tx_bit_q;
    logic [7:0] tx_shift_q;
    logic       tx_parbit_q, tx_bit8_q, tx_paren_q, tx_stop2_q;
    logic       w_tx_load, w_tx_end, w_tx_out;
    logic [2:0] w_tx_nbm1;

    assign w_tx_end  = w_tick && (tx_tcnt_q == 4'hF);
    assign w_tx_nbm1 = tx_bit8_q ? 3'd7 : 3'd6;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) tx_state_q <= S_IDLE;
        else            tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        w_tx_load  = 1'b0;
        case (tx_state_q)
            S_IDLE:   if (w_tick && !w_tx_empty) begin
                          tx_state_d = S_START;
                          w_tx_load  = 1'b1;
                      end
            S_START:  if (w_tx_end) tx_state_d = S_DATA;
            S_DATA:   if (w_tx_end && tx_bit_q == w_tx_nbm1)
                          tx_state_d = tx_paren_q ? S_PARITY : S_STOP1;
            S_PARITY: if (w_tx_end) tx_state_d = S_STOP1;
            S_STOP1, S_STOP2:
                      if (w_tx_end) begin
                          if (tx_state_q == S_STOP1 && tx_stop2_q) begin
                              tx_state_d = S_STOP2;
                          end else if (!w_tx_empty) begin
                              tx_state_d = S_START;
                              w_tx_load  = 1'b1;
                          end else begin
                              tx_state_d = S_IDLE;
                          end
                      end
            default:  tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_out = 1'b1;
        case (tx_state_q)
            S_START:  w_tx_out = 1'b0;
            S_DATA:   w_tx_out = tx_shift_q[tx_bit_q];
            S_PARITY: w_tx_out = tx_parbit_q;
            default:  w_tx_out = 1'b1;
        endcase
    end
    assign tx_o = w_tx_out;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tx_tcnt_q   <= 4'd0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            tx_parbit_q <= 1'b0;
            tx_bit8_q   <= 1'b1;
            tx_paren_q  <= 1'b0;
            tx_stop2_q  <= 1'b0;
        end else if (w_tx_load) begin
            tx_tcnt_q   <= 4'd0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= w_tx_head;
            tx_parbit_q <= ^(bit8_i ? w_tx_head : {1'b0, w_tx_head[6:0]}) ^ odd_n_even_i;
            tx_bit8_q   <= bit8_i;
            tx_paren_q  <= parity_en_i;
            tx_stop2_q  <= stop2_i;
        end else if (w_tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (w_tx_end && tx_state_q == S_DATA) tx_bit_q <= tx_bit_q + 3'd1;
        end
    end

    // ---------------- receiver ----------------
    logic [2:0] rx_state_q, rx_state_d;
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [3:0] rx_tcnt_q;
    logic [2:0] rx_bit_q;
    logic [7:0] rx_shift_q;
    logic       rx_bit8_q, rx_paren_q, rx_odd_q, rx_stop2_q;
    logic       rx_xor_q, rx_perr_q, rx_ferr_q;
    logic       w_rx_start, w_rx_done, w_rx_mid, w_rx_end, w_rx_ferr;
    logic [2:0] w_rx_nbm1;
    logic [7:0] w_rx_data;

    assign w_rx_mid  = w_tick && (rx_tcnt_q == 4'd7);
    assign w_rx_end  = w_tick && (rx_tcnt_q == 4'hF);
    assign w_rx_nbm1 = rx_bit8_q ? 3'd7 : 3'd6;
    assign w_rx_ferr = rx_ferr_q || !rx_sync_q;
    assign w_rx_data = rx_bit8_q ? rx_shift_q : {1'b0, rx_shift_q[7:1]};

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rx_state_q <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end

    // The frame completes mid-way through its last stop bit so that a
    // back-to-back start edge is never missed.
    always_comb begin
        rx_state_d = rx_state_q;
        w_rx_start = 1'b0;
        case (rx_state_q)
            S_IDLE:   if (rx_prev_q && !rx_sync_q) begin
                          rx_state_d = S_START;
                          w_rx_start = 1'b1;
                      end
            S_START:  if (w_rx_mid && rx_sync_q) rx_state_d = S_IDLE;
                      else if (w_rx_end)         rx_state_d = S_DATA;
            S_DATA:   if (w_rx_end && rx_bit_q == w_rx_nbm1)
                          rx_state_d = rx_paren_q ? S_PARITY : S_STOP1;
            S_PARITY: if (w_rx_end) rx_state_d = S_STOP1;
            S_STOP1:  if (w_rx_mid && !rx_stop2_q) rx_state_d = w_rx_ferr ? S_WAITHI : S_IDLE;
                      else if (w_rx_end)           rx_state_d = S_STOP2;
            S_STOP2:  if (w_rx_mid) rx_state_d = w_rx_ferr ? S_WAITHI : S_IDLE;
            S_WAITHI: if (rx_sync_q) rx_state_d = S_IDLE;
            default:  rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_rx_done = 1'b0;
        if (w_rx_mid) begin
            w_rx_done = (rx_state_q == S_STOP2) || (rx_state_q == S_STOP1 && !rx_stop2_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_bit8_q  <= 1'b1;
            rx_paren_q <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_stop2_q <= 1'b0;
            rx_xor_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else if (w_rx_start) begin
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_bit8_q  <= bit8_i;
            rx_paren_q <= parity_en_i;
            rx_odd_q   <= odd_n_even_i;
            rx_stop2_q <= stop2_i;
            rx_xor_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else if (w_tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (w_rx_mid) begin
                case (rx_state_q)
                    S_DATA: begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_xor_q   <= rx_xor_q ^ rx_sync_q;
                    end
                    S_PARITY:         rx_perr_q <= (rx_sync_q != (rx_xor_q ^ rx_odd_q));
                    S_STOP1, S_STOP2: rx_ferr_q <= w_rx_ferr;
                    default:          rx_ferr_q <= rx_ferr_q;
                endcase
            end
            if (w_rx_end && rx_state_q == S_DATA) rx_bit_q <= rx_bit_q + 3'd1;
        end
    end

    // Sticky flags: a set in the same cycle as a read-clear takes priority.
    logic parity_err_q, framing_err_q, overflow_q;
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (w_rx_done && rx_perr_q)      parity_err_q  <= 1'b1;
            else if (w_rd_edge)              parity_err_q  <= 1'b0;
            if (w_rx_done && w_rx_ferr)      framing_err_q <= 1'b1;
            else if (w_rd_edge)              framing_err_q <= 1'b0;
            if (w_rx_done && w_rx_full && !w_rd_edge) overflow_q <= 1'b1;
            else if (w_rd_edge)              overflow_q    <= 1'b0;
        end
    end
    assign parity_err_o  = parity_err_q;
    assign framing_err_o = framing_err_q;
    assign overflow_o    = overflow_q;

    coreuart_fifo_gen2_fifo #(.DEPTH(TX_DEPTH), .LVL_W(LVL_W), .WIDTH(8)) u_tx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (!csn_i && !wen_i),
        .pop_i     (w_tx_load),
        .wdata_i   (data_in_i),
        .rdata_o   (w_tx_head),
        .empty_o   (w_tx_empty),
        .full_o    (w_tx_full),
        .level_o   (tx_level_o)
    );

    coreuart_fifo_gen2_fifo #(.DEPTH(RX_DEPTH), .LVL_W(LVL_W), .WIDTH(8)) u_rx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (w_rx_done),
        .pop_i     (w_rd_edge),
        .wdata_i   (w_rx_data),
        .rdata_o   (data_out_o),
        .empty_o   (w_rx_empty),
        .full_o    (w_rx_full),
        .level_o   (rx_level_o)
    );

    assign txrdy_o = !w_tx_full;
    assign rxrdy_o = !w_rx_empty;
endmodule
`default_nettype wire

// File: tb/tb_coreuart_fifo_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_coreuart_fifo_gen2 : self-checking bench for coreuart_fifo_gen2.       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_coreuart_fifo_gen2;
    localparam int TXD = 16;
    localparam int RXD = 4;
    localparam int LVL = 5;

    logic           clk = 1'b0;
    logic           reset_n, csn, wen, oen, rx, bit8, parity_en, odd_n_even, stop2;
    logic           loop, rx_drv;
    logic [7:0]     data_in, data_out;
    logic [12:0]    baud_val;
    logic           tx, txrdy, rxrdy, parity_err, framing_err, overflow;
    logic [LVL-1:0] tx_level, rx_level;
    logic [7:0]     tx_q[$];
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    coreuart_fifo_gen2 #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .LVL_W(LVL)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .csn_i(csn), .wen_i(wen), .oen_i(oen),
        .data_in_i(data_in), .rx_i(rx), .baud_val_i(baud_val), .bit8_i(bit8),
        .parity_en_i(parity_en), .odd_n_even_i(odd_n_even), .stop2_i(stop2),
        .data_out_o(data_out), .tx_o(tx), .txrdy_o(txrdy), .rxrdy_o(rxrdy),
        .parity_err_o(parity_err), .framing_err_o(framing_err), .overflow_o(overflow),
        .tx_level_o(tx_level), .rx_level_o(rx_level)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; csn = 1'b1; wen = 1'b1; oen = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic set_cfg(input bit b8, input bit pe, input bit odd, input bit s2);
        bit8 = b8; parity_en = pe; odd_n_even = odd; stop2 = s2;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        csn = 1'b0; wen = 1'b0; data_in = b;
        @(negedge clk);
        csn = 1'b1; wen = 1'b1;
    endtask

    task automatic read_pop();
        @(negedge clk);
        csn = 1'b0; oen = 1'b0;
        @(negedge clk);
        csn = 1'b1; oen = 1'b1;
    endtask

    // Drive one 8-bit frame on the bench RX line at 16 clocks per bit.
    task automatic send_frame(input logic [7:0] b, input bit pe, input bit pbit, input bit stopv);
        logic [10:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = b[i]; n++; end
        if (pe) begin bits[n] = pbit; n++; end
        bits[n] = stopv; n++;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_drv = bits[i];
            idle(15);
        end
        @(negedge clk);
        rx_drv = 1'b1;
        idle(24);
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    function automatic void model_frame(input logic [7:0] b, input bit b8, input bit pe,
                                        input bit odd, input bit s2,
                                        output logic [11:0] bits, output int n);
        int data, nb, ones;
        data = b8 ? int'(b) : int'(b) % 128;
        nb   = b8 ? 8 : 7;
        ones = 0;
        bits = '1;
        n    = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            bits[n] = ((data >> i) % 2) == 1;
            ones += (data >> i) % 2;
            n++;
        end
        if (pe) begin bits[n] = ((ones % 2) == 1) ^ odd; n++; end
        bits[n] = 1'b1; n++;
        if (s2) begin bits[n] = 1'b1; n++; end
    endfunction

    task automatic wait_tx_low(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    task automatic decode_byte(input int limit, output logic [7:0] b, output bit found);
        b = 8'd0;
        wait_tx_low(limit, found);
        if (found) begin
            idle(8);
            for (int i = 0; i < 8; i++) begin idle(16); b[i] = tx; end
            idle(16);
        end
    endtask

    task automatic test_reset();
        baud_val = 13'd0; loop = 1'b0; rx_drv = 1'b1;
        set_cfg(1, 0, 0, 0);
        do_reset();
        send_frame(8'h5A, 0, 0, 0);
        checks++;
        if ({rxrdy, framing_err} !== 2'b11) begin
            errors++; $display("FAIL reset_pre_rx: rxrdy,ferr=%b want 11", {rxrdy, framing_err});
        end
        write_byte(8'h00);
        write_byte(8'h00);
        idle(40);
        checks++;
        if (tx !== 1'b0 || tx_level !== 5'd1) begin
            errors++; $display("FAIL reset_pre_tx: tx=%b lvl=%0d want 0/1", tx, tx_level);
        end
        @(negedge clk);
        reset_n = 1'b0;
        idle(2);
        checks++;
        if ({tx, txrdy, rxrdy, parity_err, framing_err, overflow} !== 6'b110000) begin
            errors++; $display("FAIL reset_outputs: got %b want 110000",
                               {tx, txrdy, rxrdy, parity_err, framing_err, overflow});
        end
        checks++;
        if (tx_level !== 5'd0 || rx_level !== 5'd0 || data_out !== 8'h00) begin
            errors++; $display("FAIL reset_levels: tx=%0d rx=%0d dout=%h want 0/0/00",
                               tx_level, rx_level, data_out);
        end
        reset_n = 1'b1;
        idle(20);
        checks++;
        if (tx !== 1'b1 || tx_level !== 5'd0) begin
            errors++; $display("FAIL reset_release: tx=%b lvl=%0d want 1/0", tx, tx_level);
        end
    endtask

    task automatic test_tx_frame(input logic [7:0] b, input bit b8, input bit pe,
                                 input bit odd, input bit s2);
        logic [11:0] exp_bits;
        int n;
        bit found;
        set_cfg(b8, pe, odd, s2);
        model_frame(b, b8, pe, odd, s2, exp_bits, n);
        write_byte(b);
        wait_tx_low(64, found);
        checks++;
        if (!found) begin
            errors++; $display("FAIL tx_start: byte %h no start bit within 64 clks", b);
            return;
        end
        for (int o = 1; o < 16 * n; o++) begin
            @(negedge clk);
            if ((o % 16) == 0 || (o % 16) == 15) begin
                checks++;
                if (tx !== exp_bits[o / 16]) begin
                    errors++;
                    $display("FAIL tx_bit: byte %h cfg %0d%0d%0d%0d bit %0d clk %0d got %b want %b",
                             b, b8, pe, odd, s2, o / 16, o, tx, exp_bits[o / 16]);
                end
            end
        end
        idle(20);
    endtask

    task automatic test_tx_timing();
        baud_val = 13'd0; loop = 1'b0; rx_drv = 1'b1;
        do_reset();
        test_tx_frame(8'h55, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            test_tx_frame(8'($urandom_range(255)), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    task automatic loopback_check(input bit b8, input bit pe, input bit odd, input bit s2);
        int n;
        logic [7:0] want;
        n = tx_q.size();
        set_cfg(b8, pe, odd, s2);
        loop = 1'b1;
        foreach (tx_q[i]) write_byte(tx_q[i]);
        idle(n * 12 * 16 + 60);
        checks++;
        if (rx_level !== LVL'(n)) begin
            errors++; $display("FAIL loop_level: got %0d want %0d", rx_level, n);
        end
        checks++;
        if ({parity_err, framing_err, overflow} !== 3'b000) begin
            errors++; $display("FAIL loop_flags: got %b want 000", {parity_err, framing_err, overflow});
        end
        for (int i = 0; i < n; i++) begin
            want = b8 ? tx_q[i] : (tx_q[i] & 8'h7F);
            checks++;
            if (data_out !== want) begin
                errors++; $display("FAIL loop_data[%0d]: got %h want %h", i, data_out, want);
            end
            read_pop();
        end
        checks++;
        if (rx_level !== 5'd0 || rxrdy !== 1'b0) begin
            errors++; $display("FAIL loop_drain: lvl=%0d rxrdy=%b want 0/0", rx_level, rxrdy);
        end
        tx_q.delete();
        loop = 1'b0;
    endtask

    task automatic test_loopback();
        int n;
        baud_val = 13'd0; rx_drv = 1'b1; loop = 1'b0;
        do_reset();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        loopback_check(1, 1, 1, 1);
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(4, 1);
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(255)));
            loopback_check(1'($urandom_range(1)), 1'($urandom_range(1)),
                           1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    task automatic test_tx_full();
        logic [7:0] b;
        bit found;
        baud_val = 13'd8191; loop = 1'b0; rx_drv = 1'b1;
        set_cfg(1, 0, 0, 0);
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            csn = 1'b0; wen = 1'b0; data_in = 8'(i + 1);
            @(negedge clk);
        end
        csn = 1'b1; wen = 1'b1;
        checks++;
        if (tx_level !== 5'd16 || txrdy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL tx_full: lvl=%0d txrdy=%b tx=%b want 16/0/1", tx_level, txrdy, tx);
        end
        baud_val = 13'd0;
        for (int i = 0; i < 16; i++) begin
            decode_byte(i == 0 ? 9000 : 64, b, found);
            checks++;
            if (!found || b !== 8'(i + 1)) begin
                errors++; $display("FAIL tx_full_byte[%0d]: found=%b got %h want %h", i, found, b, 8'(i + 1));
            end
        end
        wait_tx_low(400, found);
        checks++;
        if (found || tx_level !== 5'd0) begin
            errors++; $display("FAIL tx_full_17th: extra_frame=%b lvl=%0d want 0/0", found, tx_level);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [5];
        baud_val = 13'd0; loop = 1'b0; rx_drv = 1'b1;
        set_cfg(1, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom_range(255));
            send_frame(bytes[i], 0, 0, 1);
        end
        checks++;
        if (overflow !== 1'b1 || rx_level !== 5'd4) begin
            errors++; $display("FAIL ovf_set: ovf=%b lvl=%0d want 1/4", overflow, rx_level);
        end
        checks++;
        if (data_out !== bytes[0]) begin
            errors++; $display("FAIL ovf_data[0]: got %h want %h", data_out, bytes[0]);
        end
        read_pop();
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: ovf=%b want 0", overflow);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (data_out !== bytes[i]) begin
                errors++; $display("FAIL ovf_data[%0d]: got %h want %h", i, data_out, bytes[i]);
            end
            read_pop();
        end
    endtask

    task automatic test_errors();
        logic [7:0] b0, b1;
        baud_val = 13'd0; loop = 1'b0; rx_drv = 1'b1;
        set_cfg(1, 0, 0, 0);
        do_reset();
        @(negedge clk);
        rx_drv = 1'b0;
        idle(4);
        rx_drv = 1'b1;
        idle(40);
        checks++;
        if (rx_level !== 5'd0 || {parity_err, framing_err, overflow} !== 3'b000) begin
            errors++; $display("FAIL glitch: lvl=%0d flags=%b want 0/000",
                               rx_level, {parity_err, framing_err, overflow});
        end
        b0 = 8'($urandom_range(255));
        send_frame(b0, 0, 0, 0);
        checks++;
        if (framing_err !== 1'b1 || parity_err !== 1'b0 || rx_level !== 5'd1) begin
            errors++; $display("FAIL framing: ferr=%b perr=%b lvl=%0d want 1/0/1",
                               framing_err, parity_err, rx_level);
        end
        set_cfg(1, 1, 0, 0);
        b1 = 8'($urandom_range(255));
        send_frame(b1, 1, ~(^b1), 1);
        checks++;
        if (parity_err !== 1'b1 || rx_level !== 5'd2 || data_out !== b0) begin
            errors++; $display("FAIL parity: perr=%b lvl=%0d dout=%h want 1/2/%h",
                               parity_err, rx_level, data_out, b0);
        end
        read_pop();
        checks++;
        if (parity_err !== 1'b0 || framing_err !== 1'b0 || data_out !== b1) begin
            errors++; $display("FAIL err_clear: perr=%b ferr=%b dout=%h want 0/0/%h",
                               parity_err, framing_err, data_out, b1);
        end
    endtask

    initial begin
        reset_n = 1'b0; csn = 1'b1; wen = 1'b1; oen = 1'b1; data_in = 8'h00;
        baud_val = 13'd0; loop = 1'b0; rx_drv = 1'b1;
        set_cfg(1, 0, 0, 0);
        test_reset();
        test_tx_timing();
        test_loopback();
        test_tx_full();
        test_overflow();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
